// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Steps through the microcode of one instruction. Each instruction lasts a
//   fixed number of enabled clocks (5, 7 or 12). The sequencer starts at
//   base_addr. It executes one ROM entry per enabled clock until it reaches
//   an entry marked "last", and then waits out the remaining clocks in HOLD.
//   The ROM is synchronous. rom_addr is registered here, so the entry
//   addressed after enabled clock T(k) is executed on enabled clock T(k+1).
//
// Ports
//   clk, reset_n   : rising-edge clock; synchronous active-low reset
//   clk_en         : CPU clock enable; state advances only when it is high
//   start          : request from the decoder to run one instruction (accepted in IDLE only)
//   base_addr      : first microcode address of the instruction
//   instr_len      : 0 = 5 clocks, 1 = 7 clocks, 2 or 3 = 12 clocks
//   rom_addr       : registered microcode ROM address
//   rom_data       : [14] last, [13:12] cycle type, [11:6] src, [5:0] dst
//   fetch_en       : register-fetch strobe of the executing entry
//   write_en       : register-write strobe of the executing entry
//   src_reg        : source-register select of the executing entry, 0 otherwise
//   dst_reg        : destination-register select of the executing entry, 0 otherwise
//   busy           : high whenever the sequencer is not IDLE
//   done           : single enabled-clock pulse on the final clock of an instruction
//   overrun        : sticky flag, set when the instruction ran out of clocks
//                    before its microcode reached a "last" entry
//
// Build option
//   SEQ_OVERRUN_CHECK_EN : when defined, overrun detection is built in.
//                          When undefined, overrun is tied to 0.
module microcode_sequencer #(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int REG_ID_WIDTH   = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk_en,
  input  logic                      start,
  input  logic [ROM_ADDR_WIDTH-1:0] base_addr,
  input  logic [1:0]                instr_len,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [14:0]               rom_data,
  output logic                      fetch_en,
  output logic                      write_en,
  output logic [REG_ID_WIDTH-1:0]   src_reg,
  output logic [REG_ID_WIDTH-1:0]   dst_reg,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]                cnt_q, cnt_d;
  // The value the counter holds on the final clock (len-1).
  logic [3:0]                end_cnt_q, end_cnt_d;
  logic                      at_end;
  logic                      entry_last;
  logic [1:0]                entry_cycle;

`ifdef SEQ_OVERRUN_CHECK_EN
  logic                      overrun_q, overrun_d;
`endif

  function automatic logic [3:0] final_count(input logic [1:0] len_code);
    case (len_code)
      2'd0:    final_count = 4'd4;
      2'd1:    final_count = 4'd6;
      default: final_count = 4'd11;
    endcase
  endfunction

  assign at_end      = (cnt_q == end_cnt_q);
  assign entry_last  = rom_data[14];
  assign entry_cycle = rom_data[13:12];

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    end_cnt_d  = end_cnt_q;
    fetch_en   = 1'b0;
    write_en   = 1'b0;
    src_reg    = '0;
    dst_reg    = '0;
    done       = 1'b0;
`ifdef SEQ_OVERRUN_CHECK_EN
    overrun_d  = overrun_q;
`endif

    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rom_addr_d = base_addr;
            end_cnt_d  = final_count(instr_len);
            cnt_d      = 4'd1;
            state_d    = RUN;
          end
        end

        RUN: begin
          // Cycle-type code 3 is treated like NONE: it gives no strobe.
          fetch_en   = (entry_cycle == 2'd1);
          write_en   = (entry_cycle == 2'd2);
          src_reg    = REG_ID_WIDTH'(rom_data[11:6]);
          dst_reg    = REG_ID_WIDTH'(rom_data[5:0]);
          rom_addr_d = rom_addr_q + ROM_ADDR_WIDTH'(1);
          cnt_d      = cnt_q + 4'd1;
          if (at_end) begin
            // The instruction length wins. The microcode is cut off even if
            // this entry is not marked last.
            done    = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
`ifdef SEQ_OVERRUN_CHECK_EN
            if (!entry_last) overrun_d = 1'b1;
`endif
          end else if (entry_last) begin
            state_d = HOLD;
          end
        end

        HOLD: begin
          cnt_d = cnt_q + 4'd1;
          if (at_end) begin
            done    = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      cnt_q      <= 4'd0;
      end_cnt_q  <= 4'd0;
`ifdef SEQ_OVERRUN_CHECK_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      end_cnt_q  <= end_cnt_d;
`ifdef SEQ_OVERRUN_CHECK_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != IDLE);

`ifdef SEQ_OVERRUN_CHECK_EN
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer.
// A behavioural model predicts every output on each falling clock edge.
// The model describes an instruction by the number of enabled clocks since
// it was accepted and by the index of its first "last" entry. Directed
// scenarios add checks against hand-computed literal values.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [7:0]  base_addr;
  logic [1:0]  instr_len;
  logic [7:0]  rom_addr;
  logic [14:0] rom_data;
  logic        fetch_en, write_en, busy, done, overrun;
  logic [5:0]  src_reg, dst_reg;

  logic [14:0] rom [0:255];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: rom_addr is the registered address held in the DUT.
  assign rom_data = rom[rom_addr];

  microcode_sequencer #(.ROM_ADDR_WIDTH(8), .REG_ID_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .base_addr(base_addr), .instr_len(instr_len), .rom_addr(rom_addr),
    .rom_data(rom_data), .fetch_en(fetch_en), .write_en(write_en),
    .src_reg(src_reg), .dst_reg(dst_reg), .busy(busy), .done(done),
    .overrun(overrun)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] ent(input bit last, input int cyc,
                                      input int src, input int dst);
    ent = {last, 2'(cyc), 6'(src), 6'(dst)};
  endfunction

  // ---------------- behavioural model ----------------
  bit         m_active = 0;
  int         m_base, m_len, m_n, m_fl;
  logic [7:0] m_addr = 8'h00;
  bit         m_ovf = 0;

  always @(negedge clk) begin
    bit          exec;
    int          idx;
    logic [14:0] e;
    int          ef, ew, es, ed, edn, eovf;
    exec = 0; e = '0; ef = 0; ew = 0; es = 0; ed = 0; edn = 0;
    if (m_active) begin
      idx  = m_n - 1;
      exec = (m_fl < 0) || (idx <= m_fl);
      e    = rom[(m_base + idx) & 255];
    end
    if (reset_n) begin
      if (m_active && clk_en) begin
        if (exec) begin
          ef = (e[13:12] == 2'd1);
          ew = (e[13:12] == 2'd2);
          es = e[11:6];
          ed = e[5:0];
        end
        edn = (m_n == m_len - 1);
      end
`ifdef SEQ_OVERRUN_CHECK_EN
      eovf = m_ovf;
`else
      eovf = 0;
`endif
      chk("cmp_busy", busy, m_active);
      chk("cmp_rom_addr", rom_addr, m_addr);
      chk("cmp_fetch_en", fetch_en, ef);
      chk("cmp_write_en", write_en, ew);
      chk("cmp_src_reg", src_reg, es);
      chk("cmp_dst_reg", dst_reg, ed);
      chk("cmp_done", done, edn);
      chk("cmp_overrun", overrun, eovf);
    end
    // Advance the model to the state after the next rising edge.
    if (!reset_n) begin
      m_active = 0; m_addr = 8'h00; m_ovf = 0;
    end else if (clk_en) begin
      if (m_active) begin
        if (exec) m_addr = m_addr + 8'd1;
        if (m_n == m_len - 1) begin
          if (exec && !e[14]) m_ovf = 1;
          m_active = 0;
        end else begin
          m_n++;
        end
      end else if (start) begin
        m_active = 1;
        m_base   = base_addr;
        m_len    = (instr_len == 2'd0) ? 5 : (instr_len == 2'd1) ? 7 : 12;
        m_n      = 1;
        m_addr   = base_addr;
        m_fl     = -1;
        for (int j = 0; j < m_len; j++)
          if (m_fl < 0 && rom[(m_base + j) & 255][14]) m_fl = j;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick; @(posedge clk); #1; endtask
  task automatic neg;  @(negedge clk);     endtask

  task automatic run_none(input logic [1:0] code, input string nm);
    int done_k, busy_cnt;
    start = 1; base_addr = 8'h20; instr_len = code;
    tick;
    start = 0;
    done_k = -1; busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      neg;
      if (busy) busy_cnt++;
      if (done && done_k < 0) done_k = k;
      tick;
    end
    chk({nm, "_done_clock"}, done_k, 11);
    chk({nm, "_busy_clocks"}, busy_cnt, 11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, done_at;
    int exp_ovf;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h10] = ent(0, 1, 1, 0);
    rom[8'h11] = ent(1, 2, 0, 3);
    rom[8'h20] = ent(1, 0, 5, 9);
    rom[8'hFE] = ent(0, 1, 1, 2);
    rom[8'hFF] = ent(0, 2, 3, 4);
    rom[8'h00] = ent(0, 0, 5, 6);
    rom[8'h01] = ent(0, 1, 7, 8);
    rom[8'h30] = ent(0, 1, 2, 0);
    rom[8'h31] = ent(0, 2, 0, 4);
    rom[8'h32] = ent(0, 1, 7, 0);
    rom[8'h33] = ent(1, 0, 0, 0);
`ifdef SEQ_OVERRUN_CHECK_EN
    exp_ovf = 1;
`else
    exp_ovf = 0;
`endif

    reset_n = 0; clk_en = 0; start = 0; base_addr = 0; instr_len = 0;
    repeat (3) tick;
    neg;
    chk("reset_busy", busy, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_done", done, 0);
    chk("reset_strobes", {fetch_en, write_en}, 0);
    chk("reset_overrun", overrun, 0);
    tick;
    reset_n = 1; clk_en = 1;

    // CYCLE5 FETCH then WRITE(last), HOLD, done
    start = 1; base_addr = 8'h10; instr_len = 2'd0;
    tick;
    start = 0;
    neg; chk("c5_t1_fetch", fetch_en, 1); chk("c5_t1_src", src_reg, 1); tick;
    neg; chk("c5_t2_write", write_en, 1); chk("c5_t2_dst", dst_reg, 3); tick;
    neg; chk("c5_t3_hold_busy", busy, 1); chk("c5_t3_no_strobe", {fetch_en, write_en}, 0); tick;
    neg; chk("c5_t4_done", done, 1); tick;
    neg; chk("c5_idle", busy, 0); chk("c5_rom_addr", rom_addr, 8'h12); tick;

    // CYCLE12 single NONE entry; code 3 behaves the same
    run_none(2'd2, "c12");
    run_none(2'd3, "len3");

    // Address wrap and overrun
    start = 1; base_addr = 8'hFE; instr_len = 2'd0;
    tick;
    start = 0;
    neg; chk("wrap_k1_addr", rom_addr, 8'hFE); tick;
    neg; chk("wrap_k2_addr", rom_addr, 8'hFF); tick;
    neg; chk("wrap_k3_addr", rom_addr, 8'h00); tick;
    neg; chk("wrap_t4_done", done, 1); chk("wrap_t4_fetch", fetch_en, 1); tick;
    neg; chk("wrap_end_addr", rom_addr, 8'h02); chk("wrap_overrun", overrun, exp_ovf);
    chk("wrap_idle", busy, 0); tick;

    // CYCLE7 with clk_en toggling
    start = 1; base_addr = 8'h30; instr_len = 2'd1; clk_en = 1;
    tick;
    start = 0;
    en_cnt = 1; done_at = 0;
    for (int i = 0; i < 20; i++) begin
      clk_en = i[0];
      neg;
      if (clk_en) begin
        en_cnt++;
        if (done) done_at = en_cnt;
      end
      tick;
    end
    clk_en = 1;
    chk("gate_done_after", done_at, 7);
    tick;

    // Reset in the middle of a CYCLE7 instruction (clk_en low at that edge)
    start = 1; base_addr = 8'h30; instr_len = 2'd1;
    tick;
    start = 0;
    tick;
    reset_n = 0; clk_en = 0;
    tick;
    reset_n = 1; clk_en = 1; start = 1; base_addr = 8'h30; instr_len = 2'd1;
    neg;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rom_addr", rom_addr, 0);
    chk("rst_mid_strobes", {fetch_en, write_en, done}, 0);
    chk("rst_mid_overrun", overrun, 0);
    tick;
    start = 0;
    neg; chk("rst_reaccept_busy", busy, 1); chk("rst_reaccept_addr", rom_addr, 8'h30);
    chk("rst_reaccept_src", src_reg, 2);
    repeat (8) tick;

    // start held high with CYCLE5
    start = 1; base_addr = 8'h10; instr_len = 2'd0;
    tick;
    repeat (3) begin neg; tick; end
    neg; chk("hold_t4_done", done, 1); tick;
    neg; chk("hold_no_accept_on_done", busy, 0); tick;
    neg; chk("hold_t5_accept", busy, 1); chk("hold_t5_addr", rom_addr, 8'h10);
    chk("hold_t5_fetch", fetch_en, 1);
    tick;
    start = 0;
    repeat (8) tick;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
